// File: rtl/shared_buff_mq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shared_buff_mq_pkg
// Brief    : Shared types and helpers for the multi-queue shared buffer.
// Revision : 1.0 - initial release
// ============================================================================
package shared_buff_mq_pkg;

  // Queue-state fields are sized for the largest supported store (D <= 256).
  localparam int unsigned QS_PTR_W = 8;
  localparam int unsigned QS_CNT_W = 9;

  typedef struct packed {
    logic [QS_PTR_W-1:0] head;
    logic [QS_PTR_W-1:0] tail;
    logic [QS_CNT_W-1:0] cnt;
  } q_state_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned onehot2idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_buff_freelist.sv
`default_nettype none
// ============================================================================
// Module   : shared_buff_freelist
// Brief    : Free-slot list plus the shared next[] link store.
// Revision : 1.0 - initial release
// ============================================================================
module shared_buff_freelist
  import shared_buff_mq_pkg::*;
#(
  parameter int unsigned D  = 8,
  parameter int unsigned PW = 3,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          alloc_i,
  output logic [PW-1:0] alloc_ptr_o,
  input  logic          append_i,
  input  logic [PW-1:0] append_ptr_i,
  input  logic          splice_i,
  input  logic [PW-1:0] splice_head_i,
  input  logic [PW-1:0] splice_tail_i,
  input  logic [CW-1:0] splice_cnt_i,
  input  logic          link_i,
  input  logic [PW-1:0] link_from_i,
  input  logic [PW-1:0] link_to_i,
  input  logic [PW-1:0] rd_ptr_i,
  output logic [PW-1:0] rd_next_o,
  output logic [CW-1:0] free_cnt_o
);

  logic [PW-1:0] r_next [D];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_cnt;

  assign alloc_ptr_o = r_head;
  assign rd_next_o   = r_next[rd_ptr_i];
  assign free_cnt_o  = r_cnt;

  // Splice never coincides with alloc/append: flush blocks push and pop.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(D); i++) begin
        r_next[i] <= PW'((i + 1) % int'(D));
      end
      r_head <= '0;
      r_tail <= PW'(D - 1);
      r_cnt  <= CW'(D);
    end else begin
      if (link_i) r_next[link_from_i] <= link_to_i;
      if (splice_i) begin
        if (r_cnt == '0) r_head <= splice_head_i;
        else             r_next[r_tail] <= splice_head_i;
        r_tail <= splice_tail_i;
        r_cnt  <= r_cnt + splice_cnt_i;
      end else begin
        case ({alloc_i, append_i})
          2'b10: begin
            r_head <= r_next[r_head];
            r_cnt  <= r_cnt - CW'(1);
          end
          2'b01: begin
            if (r_cnt == '0) r_head <= append_ptr_i;
            else             r_next[r_tail] <= append_ptr_i;
            r_tail <= append_ptr_i;
            r_cnt  <= r_cnt + CW'(1);
          end
          2'b11: begin
            // A lone free slot is consumed, so the appended slot becomes the head.
            if (r_cnt == CW'(1)) begin
              r_head <= append_ptr_i;
            end else begin
              r_next[r_tail] <= append_ptr_i;
              r_head         <= r_next[r_head];
            end
            r_tail <= append_ptr_i;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shared_buff_mq.sv
`default_nettype none
// ============================================================================
// Module   : shared_buff_mq
// Brief    : Q linked-list FIFOs sharing a D-slot store; private reservation
//            plus shared pool. SHARED_BUFF_SVA_EN compiles in assertions.
// Revision : 1.0 - initial release
// ============================================================================
module shared_buff_mq
  import shared_buff_mq_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned D  = 8,
  parameter int unsigned Q  = 4,
  parameter int unsigned P  = 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  push_i,
  input  logic [Q-1:0]          push_sel_i,
  input  logic [DW-1:0]         push_data_i,
  output logic [Q-1:0]          ready_o,
  input  logic                  pop_i,
  input  logic [Q-1:0]          pop_sel_i,
  output logic [Q-1:0]          valid_o,
  output logic [Q*DW-1:0]       pop_data_o,
  output logic [DW-1:0]         data_o,
  input  logic                  flush_i,
  input  logic [Q-1:0]          flush_sel_i,
  output logic [Q*cnt_w(D)-1:0] count_o
);

  localparam int unsigned PW     = ptr_w(D);
  localparam int unsigned CW     = cnt_w(D);
  localparam int unsigned SHARED = D - Q * P;
  localparam int unsigned QIW    = (Q > 1) ? $clog2(Q) : 1;

  generate
    if (D <= Q * P) begin : g_chk_pool
      $error("shared_buff_mq: D must exceed Q*P");
    end
    if (Q < 2 || Q > 32) begin : g_chk_q
      $error("shared_buff_mq: Q must be in 2..32");
    end
    if (PW > QS_PTR_W || CW > QS_CNT_W) begin : g_chk_d
      $error("shared_buff_mq: D exceeds queue-state field width");
    end
  endgenerate

  q_state_t       r_qs     [Q];
  q_state_t       w_qs_nxt [Q];
  logic [DW-1:0]  r_data   [D];
  logic [CW-1:0]  w_cnt    [Q];
  logic [CW-1:0]  w_shared_used;
  logic [CW-1:0]  w_free_cnt;
  logic [Q-1:0]   w_ready, w_valid, w_push_q, w_pop_q, w_flush_q;
  logic           w_push_fire, w_pop_fire, w_flush_fire, w_link;
  logic [QIW-1:0] w_push_idx, w_pop_idx, w_flush_idx;
  logic [PW-1:0]  w_alloc_ptr, w_rd_next;
  q_state_t       w_push_st, w_pop_st, w_flush_st;

  generate
    for (genvar q = 0; q < Q; q++) begin : g_queue
      assign w_cnt[q]   = r_qs[q].cnt[CW-1:0];
      assign w_valid[q] = (w_cnt[q] != '0);
      assign w_ready[q] = !flush_i &&
                          ((w_cnt[q] < CW'(P)) || (w_shared_used < CW'(SHARED)));
      assign pop_data_o[q*DW +: DW] = w_valid[q] ? r_data[r_qs[q].head[PW-1:0]] : '0;
      assign count_o[q*CW +: CW]    = w_cnt[q];
    end
  endgenerate

  assign ready_o = w_ready;
  assign valid_o = w_valid;

  always_comb begin
    w_shared_used = '0;
    for (int q = 0; q < int'(Q); q++) begin
      if (w_cnt[q] > CW'(P)) w_shared_used = w_shared_used + (w_cnt[q] - CW'(P));
    end
  end

  always_comb begin
    data_o = '0;
    for (int q = 0; q < int'(Q); q++) begin
      if (pop_sel_i[q]) data_o = data_o | pop_data_o[q*DW +: DW];
    end
  end

  assign w_push_idx  = QIW'(onehot2idx(32'(push_sel_i)));
  assign w_pop_idx   = QIW'(onehot2idx(32'(pop_sel_i)));
  assign w_flush_idx = QIW'(onehot2idx(32'(flush_sel_i)));
  assign w_push_st   = r_qs[w_push_idx];
  assign w_pop_st    = r_qs[w_pop_idx];
  assign w_flush_st  = r_qs[w_flush_idx];

  assign w_push_fire  = push_i && (|(push_sel_i & w_ready)) && (w_free_cnt != '0);
  assign w_pop_fire   = pop_i && !flush_i && (|(pop_sel_i & w_valid));
  assign w_flush_fire = flush_i && (|(flush_sel_i & w_valid));
  assign w_push_q     = push_sel_i  & {Q{w_push_fire}};
  assign w_pop_q      = pop_sel_i   & {Q{w_pop_fire}};
  assign w_flush_q    = flush_sel_i & {Q{w_flush_fire}};

  // No link when the pushed slot becomes the sole entry of its queue.
  assign w_link = w_push_fire && (w_push_st.cnt != '0) &&
                  !((|(w_push_q & w_pop_q)) && (w_push_st.cnt == QS_CNT_W'(1)));

  shared_buff_freelist #(
    .D  (D),
    .PW (PW),
    .CW (CW)
  ) u_freelist (
    .clk           (clk),
    .arst_n        (arst_n),
    .alloc_i       (w_push_fire),
    .alloc_ptr_o   (w_alloc_ptr),
    .append_i      (w_pop_fire),
    .append_ptr_i  (w_pop_st.head[PW-1:0]),
    .splice_i      (w_flush_fire),
    .splice_head_i (w_flush_st.head[PW-1:0]),
    .splice_tail_i (w_flush_st.tail[PW-1:0]),
    .splice_cnt_i  (w_flush_st.cnt[CW-1:0]),
    .link_i        (w_link),
    .link_from_i   (w_push_st.tail[PW-1:0]),
    .link_to_i     (w_alloc_ptr),
    .rd_ptr_i      (w_pop_st.head[PW-1:0]),
    .rd_next_o     (w_rd_next),
    .free_cnt_o    (w_free_cnt)
  );

  always_comb begin
    for (int q = 0; q < int'(Q); q++) begin
      w_qs_nxt[q] = r_qs[q];
      if (w_flush_q[q]) begin
        w_qs_nxt[q].cnt = '0;
      end else begin
        case ({w_push_q[q], w_pop_q[q]})
          2'b10: begin
            if (r_qs[q].cnt == '0) w_qs_nxt[q].head = QS_PTR_W'(w_alloc_ptr);
            w_qs_nxt[q].tail = QS_PTR_W'(w_alloc_ptr);
            w_qs_nxt[q].cnt  = r_qs[q].cnt + QS_CNT_W'(1);
          end
          2'b01: begin
            w_qs_nxt[q].head = QS_PTR_W'(w_rd_next);
            w_qs_nxt[q].cnt  = r_qs[q].cnt - QS_CNT_W'(1);
          end
          2'b11: begin
            w_qs_nxt[q].tail = QS_PTR_W'(w_alloc_ptr);
            if (r_qs[q].cnt == QS_CNT_W'(1)) w_qs_nxt[q].head = QS_PTR_W'(w_alloc_ptr);
            else                             w_qs_nxt[q].head = QS_PTR_W'(w_rd_next);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int q = 0; q < int'(Q); q++) begin
      if (!arst_n) r_qs[q] <= '0;
      else         r_qs[q] <= w_qs_nxt[q];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_fire) r_data[w_alloc_ptr] <= push_data_i;
  end

`ifdef SHARED_BUFF_SVA_EN
  logic [CW:0] w_cnt_sum;

  always_comb begin
    w_cnt_sum = '0;
    for (int q = 0; q < int'(Q); q++) w_cnt_sum = w_cnt_sum + (CW+1)'(w_cnt[q]);
  end

  a_push_onehot: assert property (@(posedge clk) disable iff (!arst_n)
    push_i |-> $onehot(push_sel_i));
  a_pop_onehot: assert property (@(posedge clk) disable iff (!arst_n)
    pop_i |-> $onehot(pop_sel_i));
  a_flush_onehot: assert property (@(posedge clk) disable iff (!arst_n)
    flush_i |-> $onehot(flush_sel_i));
  a_push_ready: assert property (@(posedge clk) disable iff (!arst_n)
    push_i |-> |(push_sel_i & w_ready));
  a_pop_valid: assert property (@(posedge clk) disable iff (!arst_n)
    (pop_i && !flush_i) |-> |(pop_sel_i & w_valid));
  a_occupancy: assert property (@(posedge clk) disable iff (!arst_n)
    (w_cnt_sum + (CW+1)'(w_free_cnt)) == (CW+1)'(D));

  generate
    for (genvar q = 0; q < Q; q++) begin : g_sva_q
      a_cnt_max: assert property (@(posedge clk) disable iff (!arst_n)
        w_cnt[q] <= CW'(P + SHARED));
      c_pool_full: cover property (@(posedge clk) disable iff (!arst_n)
        w_cnt[q] == CW'(P + SHARED));
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_shared_buff_mq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_buff_mq
// Brief    : Directed bench for shared_buff_mq (D=8, Q=4, P=1, SHARED=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_buff_mq;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        push_i = 1'b0;
  logic [3:0]  push_sel_i = '0;
  logic [7:0]  push_data_i = '0;
  logic [3:0]  ready_o;
  logic        pop_i = 1'b0;
  logic [3:0]  pop_sel_i = '0;
  logic [3:0]  valid_o;
  logic [31:0] pop_data_o;
  logic [7:0]  data_o;
  logic        flush_i = 1'b0;
  logic [3:0]  flush_sel_i = '0;
  logic [15:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shared_buff_mq #(
    .DW (8),
    .D  (8),
    .Q  (4),
    .P  (1)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .push_i      (push_i),
    .push_sel_i  (push_sel_i),
    .push_data_i (push_data_i),
    .ready_o     (ready_o),
    .pop_i       (pop_i),
    .pop_sel_i   (pop_sel_i),
    .valid_o     (valid_o),
    .pop_data_o  (pop_data_o),
    .data_o      (data_o),
    .flush_i     (flush_i),
    .flush_sel_i (flush_sel_i),
    .count_o     (count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    push_i  = 1'b0;
    pop_i   = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic push_one(input int q, input logic [7:0] d);
    push_i      = 1'b1;
    push_sel_i  = 4'b0001 << q;
    push_data_i = d;
    tick();
  endtask

  task automatic pop_one(input int q, input logic [7:0] exp, input string tag);
    pop_i     = 1'b1;
    pop_sel_i = 4'b0001 << q;
    #1;
    check(tag, 32'(data_o), 32'(exp));
    tick();
  endtask

  task automatic push_pop(input int qp, input logic [7:0] d, input int qo,
                          input logic [7:0] exp, input string tag);
    push_i      = 1'b1;
    push_sel_i  = 4'b0001 << qp;
    push_data_i = d;
    pop_i       = 1'b1;
    pop_sel_i   = 4'b0001 << qo;
    #1;
    check(tag, 32'(data_o), 32'(exp));
    tick();
  endtask

  initial begin
    logic [7:0] v;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    check("rst_count", 32'(count_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_ready", 32'(ready_o), 32'hF);
    check("rst_pop_data", pop_data_o, 32'h0);
    check("rst_data", 32'(data_o), 32'h0);

    // First push into q0
    push_one(0, 8'hA1);
    pop_sel_i = 4'b0001;
    #1;
    check("p1_valid", 32'(valid_o), 32'h1);
    check("p1_data", 32'(data_o), 32'hA1);
    check("p1_pop_data", pop_data_o, 32'h0000_00A1);
    check("p1_count", 32'(count_o), 32'h0001);
    pop_one(0, 8'hA1, "p1_pop");
    check("p1_empty", 32'(valid_o), 32'h0);

    // q1 takes its private slot and the entire shared pool
    for (int i = 0; i < 5; i++) begin
      v = 8'h30 + 8'(i);
      push_one(1, v);
    end
    check("q1_count5", 32'(count_o), 32'h0050);
    check("q1_ready", 32'(ready_o), 32'hD);
    push_one(1, 8'hEE);
    check("q1_drop", 32'(count_o), 32'h0050);
    for (int i = 0; i < 5; i++) begin
      v = 8'h30 + 8'(i);
      pop_one(1, v, "q1_order");
    end
    check("q1_drained", 32'(valid_o), 32'h0);
    check("q1_ready_back", 32'(ready_o), 32'hF);

    // Concurrent push and pop on a single-entry queue
    push_one(0, 8'hC0);
    for (int i = 0; i < 10; i++) begin
      v = 8'hC0 + 8'(i);
      push_pop(0, v + 8'h1, 0, v, "pp_order");
      check("pp_count", 32'(count_o), 32'h0001);
    end
    pop_one(0, 8'hCA, "pp_last");
    check("pp_empty", 32'(count_o), 32'h0);

    // Flush q2; the concurrent push and pop are both blocked
    push_one(2, 8'hD0);
    push_one(2, 8'hD1);
    push_one(2, 8'hD2);
    push_one(0, 8'hF0);
    check("fl_pre_count", 32'(count_o), 32'h0301);
    flush_i     = 1'b1;
    flush_sel_i = 4'b0100;
    push_i      = 1'b1;
    push_sel_i  = 4'b1000;
    push_data_i = 8'h77;
    pop_i       = 1'b1;
    pop_sel_i   = 4'b0001;
    #1;
    check("fl_ready", 32'(ready_o), 32'h0);
    tick();
    check("fl_count", 32'(count_o), 32'h0001);
    check("fl_valid", 32'(valid_o), 32'h1);
    flush_i     = 1'b1;
    flush_sel_i = 4'b0010;
    tick();
    check("fl_empty_noop", 32'(count_o), 32'h0001);
    pop_one(0, 8'hF0, "fl_q0_kept");
    push_one(2, 8'hE0);
    push_one(2, 8'hE1);
    pop_one(2, 8'hE0, "fl_reuse0");
    pop_one(2, 8'hE1, "fl_reuse1");
    pop_i     = 1'b1;
    pop_sel_i = 4'b0100;
    tick();
    check("pop_empty", 32'(count_o), 32'h0);

    // Exhaust all 8 slots
    for (int i = 0; i < 5; i++) begin
      v = 8'h30 + 8'(i);
      push_one(1, v);
    end
    push_one(0, 8'h40);
    push_one(2, 8'h42);
    push_one(3, 8'h43);
    check("full_count", 32'(count_o), 32'h1151);
    check("full_ready", 32'(ready_o), 32'h0);
    push_pop(3, 8'h99, 1, 8'h30, "full_pp_data");
    check("full_pp_count", 32'(count_o), 32'h1141);
    check("full_pp_ready", 32'(ready_o), 32'hF);
    // Single free slot: push consumes it while the pop returns another
    push_pop(3, 8'h44, 1, 8'h31, "one_free_data");
    check("one_free_count", 32'(count_o), 32'h2131);
    push_one(0, 8'h45);
    check("refill_count", 32'(count_o), 32'h2132);
    pop_one(3, 8'h43, "drain_q3a");
    pop_one(3, 8'h44, "drain_q3b");
    pop_one(0, 8'h40, "drain_q0a");
    pop_one(0, 8'h45, "drain_q0b");
    pop_one(1, 8'h32, "drain_q1a");
    pop_one(1, 8'h33, "drain_q1b");
    pop_one(1, 8'h34, "drain_q1c");
    pop_one(2, 8'h42, "drain_q2");
    check("drain_count", 32'(count_o), 32'h0);

    // Reset in the middle of traffic
    push_one(0, 8'h11);
    push_one(0, 8'h22);
    arst_n      = 1'b0;
    push_i      = 1'b1;
    push_sel_i  = 4'b0010;
    push_data_i = 8'h99;
    @(posedge clk);
    #1;
    arst_n    = 1'b1;
    push_i    = 1'b0;
    pop_sel_i = 4'b0010;
    #1;
    check("mrst_count", 32'(count_o), 32'h0);
    check("mrst_valid", 32'(valid_o), 32'h0);
    check("mrst_ready", 32'(ready_o), 32'hF);
    check("mrst_data", 32'(data_o), 32'h0);
    push_one(1, 8'h5A);
    check("mrst_push_count", 32'(count_o), 32'h0010);
    pop_one(1, 8'h5A, "mrst_push_data");
    check("mrst_final", 32'(count_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
